disp_io_cmd_splitter: RTL and testbench
=======================================

Name: disp_io_cmd_splitter

Overview:
- Sits directly downstream of the dispatcher's I/O command buffer FIFO output.
- Consumes one {opcode, target, source, address, length} command per valid/ready handshake.
- Re-issues that command as a sequence of sub-commands, each no longer than MAX_CHUNK units, so channel controllers never see an oversize burst.
- Opcode, target ID and source ID are copied unchanged into every sub-command. Address advances by the bytes each sub-command covers.

Parameters:
- MAX_CHUNK, 16, maximum length units per sub-command; legal range 1..65535.
- UNIT_SHIFT, 9, log2 of bytes per length unit; address step per sub-command is chunk << UNIT_SHIFT.

Ports:
- iClock  in  1  single clock; all logic rises on its posedge.
- iReset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- iInOpcode  in  6  command opcode.
- iInTargetID  in  5  destination ID.
- iInSourceID  in  5  source ID.
- iInAddress  in  32  start byte address.
- iInLength  in  16  length in units.
- iInCmdValid  in  1  input command valid.
- oInCmdReady  out  1  input accepted when iInCmdValid & oInCmdReady.
- oOutOpcode  out  6  sub-command opcode.
- oOutTargetID  out  5  sub-command target.
- oOutSourceID  out  5  sub-command source.
- oOutAddress  out  32  sub-command start address.
- oOutLength  out  16  sub-command length.
- oOutLast  out  1  1 on the final sub-command of a command.
- oOutCmdValid  out  1  sub-command valid.
- iOutCmdReady  in  1  downstream ready.

Behaviour:
- Reset: all outputs other than oInCmdReady reset to 0 (valid, last, data). State resets to Idle, so oInCmdReady is 1 after reset. Reset mid-command discards the remainder; nothing further is emitted.
- States:
  - Idle: no command held.
  - Emit: a sub-command is registered on the outputs.
- Idle behaviour:
  - oInCmdReady = 1.
  - On input handshake, register opcode, IDs and address.
  - chunk = min(iInLength, MAX_CHUNK).
  - Drive oOutLength = chunk, oOutAddress = iInAddress, oOutLast = (iInLength <= MAX_CHUNK).
  - Store remaining = iInLength - chunk; set oOutCmdValid = 1; go to Emit.
- Latency: input handshake at cycle N gives the first sub-command valid at N+1 (registered outputs).
- Emit behaviour:
  - All outputs are held stable while oOutCmdValid & !iOutCmdReady.
  - On output handshake with oOutLast = 0: oOutAddress += oOutLength << UNIT_SHIFT (mod 2^32, wrap permitted); chunk = min(remaining, MAX_CHUNK); remaining -= chunk; oOutLast = (remaining_before <= MAX_CHUNK). Next sub-command is valid the following cycle with no bubble.
  - On output handshake with oOutLast = 1: oInCmdReady = iOutCmdReady, i.e. oInCmdReady = Idle | (Emit & oOutLast & iOutCmdReady). If a new input handshakes in that same cycle, load it exactly as from Idle and stay in Emit (back-to-back, no bubble). Otherwise clear oOutCmdValid and go to Idle.
- Length 0: emitted as a single sub-command with length 0, last = 1, original address.
- Arithmetic:
  - remaining is 16 bits, never negative.
  - Address step is computed at 32 bits before truncation: (16-bit length) << UNIT_SHIFT, zero-extended.
- Ordering: sub-commands are emitted strictly in order of address ascending within a command. Commands are never interleaved.
- oInCmdReady is combinational from state, oOutLast and iOutCmdReady. There is no combinational path from iInCmdValid to any output.

Decomposition:
- Shared dispatcher package holds:
  - widths: OPCODE_W = 6, ID_W = 5, ADDR_W = 32, LEN_W = 16;
  - the packed command struct typedef {opcode, target, source, address, length};
  - the state localparams Idle/Emit.
- One sub-module is natural: disp_io_chunk_calc (combinational). Inputs are remaining length and current address. Outputs are chunk, next remaining, last flag and next address.
- The FSM and registers stay in the top.

Test Plan:
- Single short command: addr 0x1000, len 10, MAX_CHUNK 16, UNIT_SHIFT 9, ready held 1 -> one sub-command (0x1000, 10, last = 1) at cycle N+1; oInCmdReady high that cycle.
- Split: addr 0x1000, len 40 -> (0x1000, 16, last 0), (0x3000, 16, last 0), (0x5000, 8, last 1) on consecutive cycles. Opcode, target and source are identical on all three.
- Backpressure: same as the split case, with iOutCmdReady toggled 0/1 every cycle -> outputs stay stable while ready = 0, the same three sub-commands are emitted, and none is dropped or duplicated.
- Back-to-back and zero length: command A (len 16) immediately followed by B (addr 0x2000, len 0) with valid held -> A is emitted last = 1, B is accepted in the same cycle as A's handshake, and B is emitted next cycle as (0x2000, 0, last 1) with no bubble.
- Wrap-around: addr 0xFFFFE000, len 32 -> (0xFFFFE000, 16), then (0x00000000, 16, last 1).
- Reset mid-command: assert iReset = 0 during the second sub-command of a len 40 command -> oOutCmdValid = 0 immediately (asynchronously). After release, oInCmdReady = 1 and no leftover sub-commands appear.

Source files
------------

// File: rtl/disp_io_cmd_splitter_pkg.sv
// Shared dispatcher definitions for the I/O command splitter: field widths,
// the packed command layout and the splitter state encoding.
package disp_io_cmd_splitter_pkg;

  localparam int OPCODE_W = 6;
  localparam int ID_W     = 5;
  localparam int ADDR_W   = 32;
  localparam int LEN_W    = 16;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [ID_W-1:0]     target;
    logic [ID_W-1:0]     source;
    logic [ADDR_W-1:0]   address;
    logic [LEN_W-1:0]    length;
  } io_cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } split_state_t;

endpackage

// File: rtl/disp_io_chunk_calc.sv
// Combinational chunk calculator: given the length still to be issued and the
// address where it starts, produces the next sub-command length, whether it is
// the final one, and what is left over for the following sub-command.
module disp_io_chunk_calc
  import disp_io_cmd_splitter_pkg::*;
#(
  parameter int MAX_CHUNK  = 16,
  parameter int UNIT_SHIFT = 9
) (
  input  logic [LEN_W-1:0]  remaining,
  input  logic [ADDR_W-1:0] address,
  output logic [LEN_W-1:0]  chunk,
  output logic [LEN_W-1:0]  next_remaining,
  output logic              last,
  output logic [ADDR_W-1:0] next_address
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHUNK);

  logic [ADDR_W-1:0] step;

  // Clip to MAX_CHUNK; the step is widened to 32 bits before shifting so no
  // address bits are lost, and the sum is allowed to wrap.
  always_comb begin
    last           = (remaining <= MAX_LEN);
    chunk          = last ? remaining : MAX_LEN;
    next_remaining = remaining - chunk;
    step           = ADDR_W'(chunk) << UNIT_SHIFT;
    next_address   = address + step;
  end

endmodule

// File: rtl/disp_io_cmd_splitter.sv
// I/O command splitter: accepts one command at a time from the dispatcher's
// command FIFO and re-issues it as a stream of sub-commands no longer than
// MAX_CHUNK units. Outputs are registered; the next chunk is precomputed so
// consecutive sub-commands (and back-to-back commands) flow without bubbles.
module disp_io_cmd_splitter
  import disp_io_cmd_splitter_pkg::*;
#(
  parameter int MAX_CHUNK  = 16,
  parameter int UNIT_SHIFT = 9
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic [OPCODE_W-1:0] iInOpcode,
  input  logic [ID_W-1:0]     iInTargetID,
  input  logic [ID_W-1:0]     iInSourceID,
  input  logic [ADDR_W-1:0]   iInAddress,
  input  logic [LEN_W-1:0]    iInLength,
  input  logic                iInCmdValid,
  output logic                oInCmdReady,
  output logic [OPCODE_W-1:0] oOutOpcode,
  output logic [ID_W-1:0]     oOutTargetID,
  output logic [ID_W-1:0]     oOutSourceID,
  output logic [ADDR_W-1:0]   oOutAddress,
  output logic [LEN_W-1:0]    oOutLength,
  output logic                oOutLast,
  output logic                oOutCmdValid,
  input  logic                iOutCmdReady
);

  split_state_t      state;
  split_state_t      state_next;

  io_cmd_t           out_cmd;
  logic              out_last;
  // Length still to issue after the sub-command currently on the outputs,
  // and the address at which that remainder starts.
  logic [LEN_W-1:0]  rem_len;
  logic [ADDR_W-1:0] rem_addr;

  logic              in_hs;
  logic              out_hs;
  logic              load;
  logic              advance;

  logic [LEN_W-1:0]  calc_rem_in;
  logic [ADDR_W-1:0] calc_addr_in;
  logic [LEN_W-1:0]  calc_chunk;
  logic [LEN_W-1:0]  calc_rem_out;
  logic              calc_last;
  logic [ADDR_W-1:0] calc_addr_out;

  assign oOutCmdValid = (state == ST_EMIT);
  assign oInCmdReady  = (state == ST_IDLE) |
                        ((state == ST_EMIT) & out_last & iOutCmdReady);

  assign in_hs   = iInCmdValid & oInCmdReady;
  assign out_hs  = oOutCmdValid & iOutCmdReady;
  assign load    = in_hs;
  assign advance = out_hs & ~out_last;

  assign oOutOpcode   = out_cmd.opcode;
  assign oOutTargetID = out_cmd.target;
  assign oOutSourceID = out_cmd.source;
  assign oOutAddress  = out_cmd.address;
  assign oOutLength   = out_cmd.length;
  assign oOutLast     = out_last;

  // Feed the calculator from the new command on a load, otherwise from the
  // stored remainder of the command in flight.
  always_comb begin
    calc_rem_in  = rem_len;
    calc_addr_in = rem_addr;
    if (load) begin
      calc_rem_in  = iInLength;
      calc_addr_in = iInAddress;
    end
  end

  disp_io_chunk_calc #(
    .MAX_CHUNK  (MAX_CHUNK),
    .UNIT_SHIFT (UNIT_SHIFT)
  ) u_chunk_calc (
    .remaining      (calc_rem_in),
    .address        (calc_addr_in),
    .chunk          (calc_chunk),
    .next_remaining (calc_rem_out),
    .last           (calc_last),
    .next_address   (calc_addr_out)
  );

  // State register.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: leave Emit only when the final sub-command is taken and no
  // new command is accepted in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (in_hs) begin
          state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_hs && out_last && !in_hs) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output and remainder registers: load a fresh command or step to the next
  // chunk; hold everything otherwise (including under backpressure).
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      out_cmd  <= '0;
      out_last <= 1'b0;
      rem_len  <= '0;
      rem_addr <= '0;
    end else if (load) begin
      out_cmd.opcode  <= iInOpcode;
      out_cmd.target  <= iInTargetID;
      out_cmd.source  <= iInSourceID;
      out_cmd.address <= iInAddress;
      out_cmd.length  <= calc_chunk;
      out_last        <= calc_last;
      rem_len         <= calc_rem_out;
      rem_addr        <= calc_addr_out;
    end else if (advance) begin
      out_cmd.address <= rem_addr;
      out_cmd.length  <= calc_chunk;
      out_last        <= calc_last;
      rem_len         <= calc_rem_out;
      rem_addr        <= calc_addr_out;
    end
  end

endmodule

// File: tb/tb_disp_io_cmd_splitter.sv
// Self-checking bench for disp_io_cmd_splitter: directed scenarios plus
// randomized commands, compared against a queue-based reference model.
module tb_disp_io_cmd_splitter;

  localparam int MAX_CHUNK  = 16;
  localparam int UNIT_SHIFT = 9;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  tg;
    logic [4:0]  src;
    logic [31:0] addr;
    logic [15:0] len;
    logic        last;
  } sub_t;

  logic        clk = 1'b0;
  logic        iReset;
  logic [5:0]  iInOpcode;
  logic [4:0]  iInTargetID;
  logic [4:0]  iInSourceID;
  logic [31:0] iInAddress;
  logic [15:0] iInLength;
  logic        iInCmdValid;
  logic        oInCmdReady;
  logic [5:0]  oOutOpcode;
  logic [4:0]  oOutTargetID;
  logic [4:0]  oOutSourceID;
  logic [31:0] oOutAddress;
  logic [15:0] oOutLength;
  logic        oOutLast;
  logic        oOutCmdValid;
  logic        iOutCmdReady;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   rmode = 0;
  sub_t exp_q[$];
  sub_t seen[$];
  sub_t snap;
  logic hold = 1'b0;

  disp_io_cmd_splitter #(
    .MAX_CHUNK  (MAX_CHUNK),
    .UNIT_SHIFT (UNIT_SHIFT)
  ) dut (
    .iClock       (clk),
    .iReset       (iReset),
    .iInOpcode    (iInOpcode),
    .iInTargetID  (iInTargetID),
    .iInSourceID  (iInSourceID),
    .iInAddress   (iInAddress),
    .iInLength    (iInLength),
    .iInCmdValid  (iInCmdValid),
    .oInCmdReady  (oInCmdReady),
    .oOutOpcode   (oOutOpcode),
    .oOutTargetID (oOutTargetID),
    .oOutSourceID (oOutSourceID),
    .oOutAddress  (oOutAddress),
    .oOutLength   (oOutLength),
    .oOutLast     (oOutLast),
    .oOutCmdValid (oOutCmdValid),
    .iOutCmdReady (iOutCmdReady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic sub_t mk(input logic [5:0] op, input logic [4:0] tg, input logic [4:0] src,
                              input logic [31:0] addr, input logic [15:0] len, input logic last);
    sub_t s;
    s.op = op; s.tg = tg; s.src = src; s.addr = addr; s.len = len; s.last = last;
    return s;
  endfunction

  // Reference model: a whole command expands into its list of sub-commands.
  task automatic model_push(input logic [5:0] op, input logic [4:0] tg, input logic [4:0] src,
                            input logic [31:0] addr, input logic [15:0] len);
    int          rem;
    int          c;
    logic [31:0] a;
    rem = int'(len);
    a   = addr;
    do begin
      c = (rem > MAX_CHUNK) ? MAX_CHUNK : rem;
      exp_q.push_back(mk(op, tg, src, a, 16'(c), rem <= MAX_CHUNK));
      a   = a + (32'(c) * (32'd1 << UNIT_SHIFT));
      rem = rem - c;
    end while (rem != 0);
  endtask

  function automatic sub_t cur_out();
    return mk(oOutOpcode, oOutTargetID, oOutSourceID, oOutAddress, oOutLength, oOutLast);
  endfunction

  // Monitor at the falling edge: everything seen here is what the next
  // rising edge will act on.
  always @(negedge clk) begin
    if (!iReset) begin
      hold = 1'b0;
    end else begin
      chk("vld", oOutCmdValid, exp_q.size() != 0);
      chk("rdy", oInCmdReady, (exp_q.size() == 0) || (exp_q.size() == 1 && iOutCmdReady));
      if (hold) chk("hold", cur_out(), snap);
      hold = 1'b0;
      if (oOutCmdValid && iOutCmdReady) begin
        if (exp_q.size() == 0) begin
          chk("extra", cur_out(), '0);
        end else begin
          chk("sub", cur_out(), exp_q[0]);
          seen.push_back(cur_out());
          void'(exp_q.pop_front());
        end
      end else if (oOutCmdValid) begin
        snap = cur_out();
        hold = 1'b1;
      end
      if (iInCmdValid && oInCmdReady)
        model_push(iInOpcode, iInTargetID, iInSourceID, iInAddress, iInLength);
    end
  end

  // Downstream ready pattern: 0 = always ready, 1 = toggle, 2 = random.
  initial begin
    iOutCmdReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       iOutCmdReady = 1'b1;
        1:       iOutCmdReady = ~iOutCmdReady;
        default: iOutCmdReady = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Present a command and hold valid until it is accepted; valid is left
  // high so a following send() is back-to-back.
  task automatic send(input logic [5:0] op, input logic [4:0] tg, input logic [4:0] src,
                      input logic [31:0] addr, input logic [15:0] len);
    bit acc;
    acc = 1'b0;
    iInOpcode = op; iInTargetID = tg; iInSourceID = src;
    iInAddress = addr; iInLength = len; iInCmdValid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (oInCmdReady) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    iReset = 1'b0;
    iInCmdValid = 1'b0;
    iInOpcode = '0; iInTargetID = '0; iInSourceID = '0; iInAddress = '0; iInLength = '0;
    repeat (3) @(negedge clk);
    chk("rst_vld",  oOutCmdValid, 0);
    chk("rst_last", oOutLast, 0);
    chk("rst_len",  oOutLength, 0);
    chk("rst_addr", oOutAddress, 0);
    chk("rst_rdy",  oInCmdReady, 1);
    @(posedge clk); #2;
    iReset = 1'b1;
    @(posedge clk); #1;

    // Single short command.
    rmode = 0; seen.delete();
    send(6'h11, 5'h03, 5'h04, 32'h0000_1000, 16'd10);
    iInCmdValid = 1'b0;
    drain();
    chk("single_n", seen.size(), 1);
    if (seen.size() == 1) chk("single_0", seen[0], mk(6'h11, 5'h03, 5'h04, 32'h1000, 16'd10, 1));

    // Split, then the same split under toggling backpressure.
    for (int pass = 0; pass < 2; pass++) begin
      rmode = pass; seen.delete();
      send(6'h22, 5'h05, 5'h06, 32'h0000_1000, 16'd40);
      iInCmdValid = 1'b0;
      drain();
      chk("split_n", seen.size(), 3);
      if (seen.size() == 3) begin
        chk("split_0", seen[0], mk(6'h22, 5'h05, 5'h06, 32'h1000, 16'd16, 0));
        chk("split_1", seen[1], mk(6'h22, 5'h05, 5'h06, 32'h3000, 16'd16, 0));
        chk("split_2", seen[2], mk(6'h22, 5'h05, 5'h06, 32'h5000, 16'd8,  1));
      end
    end

    // Back-to-back with a zero-length second command.
    rmode = 0; seen.delete();
    send(6'h01, 5'h01, 5'h02, 32'h0000_4000, 16'd16);
    send(6'h02, 5'h07, 5'h08, 32'h0000_2000, 16'd0);
    iInCmdValid = 1'b0;
    drain();
    chk("b2b_n", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("b2b_a", seen[0], mk(6'h01, 5'h01, 5'h02, 32'h4000, 16'd16, 1));
      chk("b2b_b", seen[1], mk(6'h02, 5'h07, 5'h08, 32'h2000, 16'd0,  1));
    end

    // Address wrap-around.
    seen.delete();
    send(6'h3F, 5'h1F, 5'h00, 32'hFFFF_E000, 16'd32);
    iInCmdValid = 1'b0;
    drain();
    chk("wrap_n", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("wrap_0", seen[0], mk(6'h3F, 5'h1F, 5'h00, 32'hFFFF_E000, 16'd16, 0));
      chk("wrap_1", seen[1], mk(6'h3F, 5'h1F, 5'h00, 32'h0000_0000, 16'd16, 1));
    end

    // Reset during the second sub-command of a long command.
    send(6'h05, 5'h02, 5'h03, 32'h0000_8000, 16'd40);
    iInCmdValid = 1'b0;
    @(posedge clk); #2;
    chk("mid_addr", oOutAddress, 32'h0000_A000);
    iReset = 1'b0;
    #1;
    chk("mid_rst_vld", oOutCmdValid, 0);
    chk("mid_rst_rdy", oInCmdReady, 1);
    exp_q.delete();
    @(posedge clk); #2;
    iReset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_rdy", oInCmdReady, 1);
    chk("post_rst_vld", oOutCmdValid, 0);

    // Randomized commands with random backpressure and gaps.
    for (int n = 0; n < 150; n++) begin
      logic [15:0] len;
      int          pick;
      pick = $urandom_range(0, 9);
      if (pick == 0)      len = 16'd0;
      else if (pick == 1) len = 16'(MAX_CHUNK * $urandom_range(1, 4));
      else                len = 16'($urandom_range(1, 100));
      rmode = $urandom_range(0, 2);
      send(6'($urandom), 5'($urandom), 5'($urandom), $urandom, len);
      if ($urandom_range(0, 2) != 0) begin
        iInCmdValid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    iInCmdValid = 1'b0;
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("end_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
